// File: rtl/lc3b_types.sv
// Shared LC-3b execute-stage types.
// Adds the multiply sequencer state enum and step count.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [2:0] {
    alu_add,
    alu_and,
    alu_not,
    alu_pass,
    alu_sll,
    alu_srl,
    alu_sra
  } lc3b_aluop;

  typedef enum logic [1:0] {
    MS_IDLE,
    MS_RUN,
    MS_DONE
  } lc3b_mulstate;

  localparam int MUL_STEPS = 16;

endpackage

// File: rtl/alu.sv
// LC-3b execute-stage ALU.
// Purely combinational; shifts use the low 4 bits of b.
module alu
  import lc3b_types::*;
(
  input  lc3b_aluop aluop,
  input  lc3b_word  a,
  input  lc3b_word  b,
  output lc3b_word  f
);

  always_comb begin
    f = a;
    case (aluop)
      alu_add:  f = a + b;
      alu_and:  f = a & b;
      alu_not:  f = ~a;
      alu_pass: f = a;
      alu_sll:  f = a << b[3:0];
      alu_srl:  f = a >> b[3:0];
      alu_sra:  f = lc3b_word'($signed(a) >>> b[3:0]);
      default:  f = a;
    endcase
  end

endmodule

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add 16-bit multiplier sharing the EX-stage ALU.
// Optional macro ALU_MUL_EARLY_TERM_EN ends RUN once the multiplier empties.
module alu_mul_sequencer
  import lc3b_types::*;
#(
  parameter int WIDTH = 16
) (
  input  logic      clk,
  input  logic      reset_n,
  input  lc3b_aluop pipe_aluop,
  input  lc3b_word  pipe_a,
  input  lc3b_word  pipe_b,
  output lc3b_word  pipe_f,
  input  logic      mul_start,
  input  lc3b_word  mul_a,
  input  lc3b_word  mul_b,
  output logic      mul_busy,
  output logic      mul_done,
  output lc3b_word  mul_result,
  output logic      stall
);

  if (WIDTH != $bits(lc3b_word)) begin : g_width_chk
    $error("WIDTH must match lc3b_word");
  end

  lc3b_mulstate state;
  lc3b_mulstate state_nxt;

  lc3b_word  mcand;
  lc3b_word  mplier;
  lc3b_word  acc;
  lc3b_word  step_acc;
  logic [3:0] cnt;

  lc3b_aluop alu_op;
  lc3b_word  alu_a;
  lc3b_word  alu_b;
  lc3b_word  alu_f;

  logic last_step;
  logic zero_start;

  localparam logic [3:0] LAST_CNT = 4'(MUL_STEPS - 1);

`ifdef ALU_MUL_EARLY_TERM_EN
  assign last_step  = (cnt == LAST_CNT) ||
                      ((mplier >> 1) == '0);
  assign zero_start = (mul_b == '0);
`else
  assign last_step  = (cnt == LAST_CNT);
  assign zero_start = 1'b0;
`endif

  assign step_acc = mplier[0] ? alu_f : acc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= MS_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MS_IDLE, MS_DONE: begin
        if (mul_start)
          state_nxt = zero_start ? MS_DONE : MS_RUN;
        else
          state_nxt = MS_IDLE;
      end
      MS_RUN: begin
        if (last_step) state_nxt = MS_DONE;
      end
      default: state_nxt = MS_IDLE;
    endcase
  end

  always_comb begin
    mul_busy = (state == MS_RUN);
    mul_done = (state == MS_DONE);
    stall    = mul_busy;
    alu_op   = pipe_aluop;
    alu_a    = pipe_a;
    alu_b    = pipe_b;
    if (mul_busy) begin
      alu_op = alu_add;
      alu_a  = acc;
      alu_b  = mcand;
    end
  end

  // Result captures the final step so it is valid in the DONE cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      cnt        <= '0;
      mul_result <= '0;
    end else if (state == MS_RUN) begin
      acc    <= step_acc;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 4'd1;
      if (last_step) mul_result <= step_acc;
    end else if (mul_start) begin
      mcand  <= mul_a;
      mplier <= mul_b;
      acc    <= '0;
      cnt    <= '0;
      if (zero_start) mul_result <= '0;
    end
  end

  alu u_alu (
    .aluop (alu_op),
    .a     (alu_a),
    .b     (alu_b),
    .f     (alu_f)
  );

  assign pipe_f = alu_f;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer.
// Latency expectations follow ALU_MUL_EARLY_TERM_EN when defined.
module tb_alu_mul_sequencer;
  import lc3b_types::*;

  logic      clk = 1'b0;
  logic      reset_n;
  lc3b_aluop pipe_aluop;
  lc3b_word  pipe_a;
  lc3b_word  pipe_b;
  lc3b_word  pipe_f;
  logic      mul_start;
  lc3b_word  mul_a;
  lc3b_word  mul_b;
  logic      mul_busy;
  logic      mul_done;
  lc3b_word  mul_result;
  logic      stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_mul_sequencer #(.WIDTH(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pipe_aluop (pipe_aluop),
    .pipe_a     (pipe_a),
    .pipe_b     (pipe_b),
    .pipe_f     (pipe_f),
    .mul_start  (mul_start),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_busy   (mul_busy),
    .mul_done   (mul_done),
    .mul_result (mul_result),
    .stall      (stall)
  );

  // Expected edge count (start edge included) and RUN cycles
  function automatic int exp_run(input lc3b_word b);
`ifdef ALU_MUL_EARLY_TERM_EN
    int n = 0;
    for (int i = 0; i < 16; i++) if (b[i]) n = i + 1;
    return n;
`else
    return (b == '0) ? 16 : 16;
`endif
  endfunction

  task automatic kick(input lc3b_word a, input lc3b_word b);
    @(negedge clk);
    mul_start = 1'b1;
    mul_a = a;
    mul_b = b;
    @(posedge clk);
    #1 mul_start = 1'b0;
  endtask

  task automatic wait_done(output int edges, output int stalls,
                           output bit to);
    edges = 1;
    stalls = 0;
    while (!mul_done && edges < 40) begin
      if (stall) stalls++;
      @(posedge clk);
      #1 edges++;
    end
    to = !mul_done;
  endtask

  task automatic run_mul(input lc3b_word a, input lc3b_word b,
                         input lc3b_word er, input string nm);
    int e, s;
    bit to;
    kick(a, b);
    wait_done(e, s, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL %s timeout waiting for mul_done", nm);
    end
    checks++;
    if (mul_result !== er) begin
      errors++;
      $display("FAIL %s result got %h want %h", nm, mul_result, er);
    end
    checks++;
    if (e !== exp_run(b) + 1) begin
      errors++;
      $display("FAIL %s edges got %0d want %0d", nm, e, exp_run(b) + 1);
    end
    checks++;
    if (s !== exp_run(b)) begin
      errors++;
      $display("FAIL %s stall cycles got %0d want %0d", nm, s, exp_run(b));
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({mul_busy, mul_done, stall} !== 3'b000) begin
      errors++;
      $display("FAIL reset flags got %b want 000",
               {mul_busy, mul_done, stall});
    end
    checks++;
    if (mul_result !== 16'h0000) begin
      errors++;
      $display("FAIL reset result got %h want 0000", mul_result);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_passthrough;
    pipe_aluop = alu_add; pipe_a = 16'h0003; pipe_b = 16'h0004;
    #1;
    checks++;
    if (pipe_f !== 16'h0007 || stall !== 1'b0) begin
      errors++;
      $display("FAIL pass_add got %h/%b want 0007/0", pipe_f, stall);
    end
    pipe_aluop = alu_and; pipe_a = 16'hFFF0; pipe_b = 16'h0F0F;
    #1;
    checks++;
    if (pipe_f !== 16'h0F00) begin
      errors++;
      $display("FAIL pass_and got %h want 0F00", pipe_f);
    end
    pipe_aluop = alu_not; pipe_a = 16'h00FF;
    #1;
    checks++;
    if (pipe_f !== 16'hFF00) begin
      errors++;
      $display("FAIL pass_not got %h want FF00", pipe_f);
    end
    pipe_aluop = alu_add; pipe_a = 16'h0003; pipe_b = 16'h0004;
  endtask

  task automatic test_basic;
    run_mul(16'h0007, 16'h0006, 16'h002A, "mul_7x6");
    @(posedge clk);
    #1;
    checks++;
    if (mul_done !== 1'b0 || mul_result !== 16'h002A) begin
      errors++;
      $display("FAIL done_pulse got %b/%h want 0/002A",
               mul_done, mul_result);
    end
    checks++;
    if (pipe_f !== 16'h0007) begin
      errors++;
      $display("FAIL pass_after got %h want 0007", pipe_f);
    end
  endtask

  task automatic test_wrap;
    run_mul(16'hFFFF, 16'h0003, 16'hFFFD, "mul_neg1x3");
    run_mul(16'h1234, 16'h0100, 16'h3400, "mul_shift8");
  endtask

  task automatic test_boundary;
    run_mul(16'h5555, 16'h0000, 16'h0000, "mul_zero");
    run_mul(16'h0001, 16'h8000, 16'h8000, "mul_msb");
  endtask

  task automatic test_busy;
    int e, s;
    bit to;
    kick(16'h0003, 16'hFFFF);
    repeat (4) @(posedge clk);
    @(negedge clk);
    mul_start = 1'b1; mul_a = 16'h0002; mul_b = 16'h0002;
    @(posedge clk);
    #1 mul_start = 1'b0;
    wait_done(e, s, to);
    checks++;
    if (to || mul_result !== 16'hFFFD) begin
      errors++;
      $display("FAIL busy_ignore got %h want FFFD", mul_result);
    end
    checks++;
    if (e !== 12) begin
      errors++;
      $display("FAIL busy_len got %0d want 12", e);
    end
  endtask

  task automatic test_back_to_back;
    int e, s;
    bit to;
    kick(16'h0007, 16'h0006);
    wait_done(e, s, to);
    mul_start = 1'b1; mul_a = 16'h0005; mul_b = 16'h0003;
    @(posedge clk);
    #1 mul_start = 1'b0;
    checks++;
    if (mul_busy !== 1'b1 || mul_done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept got %b/%b want 1/0", mul_busy, mul_done);
    end
    wait_done(e, s, to);
    checks++;
    if (to || mul_result !== 16'h000F) begin
      errors++;
      $display("FAIL b2b_result got %h want 000F", mul_result);
    end
    checks++;
    if (e !== exp_run(16'h0003) + 1) begin
      errors++;
      $display("FAIL b2b_len got %0d want %0d", e, exp_run(16'h0003) + 1);
    end
  endtask

  task automatic test_reset_mid;
    kick(16'h0001, 16'hFFFF);
    repeat (7) @(posedge clk);
    @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL mid_running got %b want 1", stall);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({mul_busy, mul_done, stall} !== 3'b000 ||
        mul_result !== 16'h0000) begin
      errors++;
      $display("FAIL mid_reset got %b/%h want 000/0000",
               {mul_busy, mul_done, stall}, mul_result);
    end
    @(negedge clk);
    reset_n = 1'b1;
    run_mul(16'h0005, 16'h0005, 16'h0019, "mul_5x5");
  endtask

  initial begin
    mul_start = 1'b0;
    mul_a = '0;
    mul_b = '0;
    pipe_aluop = alu_add;
    pipe_a = '0;
    pipe_b = '0;
    test_reset();
    test_passthrough();
    test_basic();
    test_wrap();
    test_boundary();
    test_busy();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
